// File: rtl/ws2812_frame_driver.sv
// ws2812_frame_driver
//   Serialises a frame of NUM_PIXELS pixel words, MSB first, onto one WS2812-style
//   data line and then holds the line low for RESET_CYCLES latch cycles.
//   Pixels arrive on a valid/ready stream. A one-entry holding register lets the
//   next pixel start on the cycle right after the current one ends.
//
//   Optional feature macro: LED_DRV_UNDERRUN_EN
//     defined   : on underrun a black pixel is inserted and underrun_err (sticky) is set
//     undefined : on underrun the line stalls low until a pixel arrives
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        begin a frame (sampled only in idle)
//   pix_data     pixel word, MSB sent first
//   pix_valid    pix_data valid
//   pix_ready    driver accepts pix_data this cycle
//   dout         serial LED data line (registered)
//   bit_strobe   high in the first cycle of every bit period
//   busy         high in every state except idle
//   frame_done   one-cycle pulse when the latch interval completes
//   underrun_err sticky underrun flag (LED_DRV_UNDERRUN_EN only)
module ws2812_frame_driver #(
    parameter int unsigned NUM_PIXELS     = 64,
    parameter int unsigned BITS_PER_PIXEL = 24,
    parameter int unsigned T0H            = 20,
    parameter int unsigned T1H            = 41,
    parameter int unsigned BIT_CYCLES     = 63,
    parameter int unsigned RESET_CYCLES   = 3600
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BITS_PER_PIXEL-1:0] pix_data,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic                      dout,
    output logic                      bit_strobe,
    output logic                      busy,
    output logic                      frame_done
`ifdef LED_DRV_UNDERRUN_EN
    ,
    output logic                      underrun_err
`endif
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BW = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
    localparam int unsigned PW = $clog2(NUM_PIXELS + 1);
    localparam int unsigned LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HI_ZERO   = CW'(T0H);
    localparam logic [CW-1:0] HI_ONE    = CW'(T1H);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_PIXEL - 1);
    localparam logic [PW-1:0] PIX_TOTAL = PW'(NUM_PIXELS);
    localparam logic [LW-1:0] LAT_LAST  = LW'(RESET_CYCLES - 1);

`ifdef LED_DRV_UNDERRUN_EN
    typedef enum logic [2:0] {StIdle, StFirst, StSend, StLatch} state_t;
`else
    typedef enum logic [2:0] {StIdle, StFirst, StSend, StStall, StLatch} state_t;
`endif

    state_t                    state;
    logic [CW-1:0]             cyc;
    logic [BW-1:0]             bit_cnt;
    logic [PW-1:0]             acc_cnt;    // pixels accepted from the stream
    logic [PW-1:0]             sent_cnt;   // pixels started on the line (incl. inserted black)
    logic [LW-1:0]             lat_cnt;
    logic [BITS_PER_PIXEL-1:0] shreg;
    logic [BITS_PER_PIXEL-1:0] hold;
    logic                      hold_valid;

    logic          xfer, bit_end, pix_end, frame_end, load_hold, direct;
    logic          hold_valid_n, ready_n;
    logic [PW-1:0] acc_n;
    logic [CW-1:0] cyc_inc, hi_len;

    always_comb begin
        xfer      = pix_valid && pix_ready;
        hi_len    = shreg[BITS_PER_PIXEL-1] ? HI_ONE : HI_ZERO;
        cyc_inc   = cyc + CW'(1);
        bit_end   = (state == StSend) && (cyc == CYC_LAST);
        pix_end   = bit_end && (bit_cnt == BIT_LAST);
        frame_end = pix_end && (sent_cnt == PIX_TOTAL);
        load_hold = pix_end && !frame_end && hold_valid;
        // A word arriving exactly at the end of a pixel with hold empty goes straight
        // into the shift register, so it is neither an underrun nor a hold write.
        direct    = pix_end && !frame_end && !hold_valid && xfer;
        acc_n     = acc_cnt + PW'(xfer);
        hold_valid_n = (xfer && !direct) || (hold_valid && !load_hold);
        ready_n   = !hold_valid_n && (acc_n < PIX_TOTAL);
    end

    // dout/bit_strobe are computed from the next-cycle counter values so the
    // registered line lines up exactly with the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            dout       <= 1'b0;
            pix_ready  <= 1'b0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cyc        <= '0;
            bit_cnt    <= '0;
            acc_cnt    <= '0;
            sent_cnt   <= '0;
            lat_cnt    <= '0;
            shreg      <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
`ifdef LED_DRV_UNDERRUN_EN
            underrun_err <= 1'b0;
`endif
        end else begin
            bit_strobe <= 1'b0;
            frame_done <= 1'b0;
            acc_cnt    <= acc_n;
            unique case (state)
                StIdle: begin
                    dout      <= 1'b0;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        state      <= StFirst;
                        busy       <= 1'b1;
                        pix_ready  <= 1'b1;
                        acc_cnt    <= '0;
                        sent_cnt   <= '0;
                        hold_valid <= 1'b0;
`ifdef LED_DRV_UNDERRUN_EN
                        underrun_err <= 1'b0;
`endif
                    end
                end
                StFirst: begin
                    dout <= 1'b0;
                    if (xfer) begin
                        state      <= StSend;
                        shreg      <= pix_data;
                        cyc        <= '0;
                        bit_cnt    <= '0;
                        sent_cnt   <= PW'(1);
                        dout       <= 1'b1;
                        bit_strobe <= 1'b1;
                        pix_ready  <= (acc_n < PIX_TOTAL);
                    end
                end
                StSend: begin
                    if (xfer && !direct) begin
                        hold       <= pix_data;
                        hold_valid <= 1'b1;
                    end else if (load_hold) begin
                        hold_valid <= 1'b0;
                    end
                    pix_ready <= ready_n;
                    if (!bit_end) begin
                        cyc  <= cyc_inc;
                        dout <= (cyc_inc < hi_len);
                    end else begin
                        cyc <= '0;
                        if (!pix_end) begin
                            shreg      <= shreg << 1;
                            bit_cnt    <= bit_cnt + BW'(1);
                            dout       <= 1'b1;
                            bit_strobe <= 1'b1;
                        end else if (frame_end) begin
                            state     <= StLatch;
                            lat_cnt   <= '0;
                            dout      <= 1'b0;
                            pix_ready <= 1'b0;
                        end else if (load_hold || direct) begin
                            shreg      <= load_hold ? hold : pix_data;
                            bit_cnt    <= '0;
                            sent_cnt   <= sent_cnt + PW'(1);
                            dout       <= 1'b1;
                            bit_strobe <= 1'b1;
                        end else begin
`ifdef LED_DRV_UNDERRUN_EN
                            // Underrun: send black so the frame keeps its length.
                            shreg        <= '0;
                            bit_cnt      <= '0;
                            sent_cnt     <= sent_cnt + PW'(1);
                            dout         <= 1'b1;
                            bit_strobe   <= 1'b1;
                            underrun_err <= 1'b1;
`else
                            state     <= StStall;
                            dout      <= 1'b0;
                            pix_ready <= 1'b1;
`endif
                        end
                    end
                end
`ifndef LED_DRV_UNDERRUN_EN
                StStall: begin
                    dout <= 1'b0;
                    if (xfer) begin
                        state      <= StSend;
                        shreg      <= pix_data;
                        cyc        <= '0;
                        bit_cnt    <= '0;
                        sent_cnt   <= sent_cnt + PW'(1);
                        dout       <= 1'b1;
                        bit_strobe <= 1'b1;
                        pix_ready  <= (acc_n < PIX_TOTAL);
                    end
                end
`endif
                StLatch: begin
                    dout      <= 1'b0;
                    pix_ready <= 1'b0;
                    if (lat_cnt == LAT_LAST) begin
                        state      <= StIdle;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// tb_ws2812_frame_driver
//   Directed bench for ws2812_frame_driver with NUM_PIXELS=3, BITS_PER_PIXEL=8 and
//   default timing. A monitor records dout high-phase lengths, bit_strobe times,
//   transfers and frame_done; a feeder drives the pixel stream from a queue.
module tb_ws2812_frame_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       dout;
    logic       bit_strobe;
    logic       busy;
    logic       frame_done;
`ifdef LED_DRV_UNDERRUN_EN
    logic       underrun_err;
`endif

    ws2812_frame_driver #(
        .NUM_PIXELS    (3),
        .BITS_PER_PIXEL(8),
        .T0H           (20),
        .T1H           (41),
        .BIT_CYCLES    (63),
        .RESET_CYCLES  (3600)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .dout        (dout),
        .bit_strobe  (bit_strobe),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef LED_DRV_UNDERRUN_EN
        ,
        .underrun_err(underrun_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_checks = 0;
    int n_errors = 0;

    // monitor state
    int strobe_q[$];
    int hi_q[$];
    int rise_t, done_t, start_t, first_xfer_t;
    int xfers, done_n, busy_falls;
    bit dout_prev, busy_prev, busy_at_done;

    // feeder state
    logic [7:0] pq[$];
    int gate = 0;
    bit fire;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        dout_prev = 0; busy_prev = 0; rise_t = 0; done_t = 0;
        forever begin
            @(negedge clk);
            if (bit_strobe) strobe_q.push_back(cyc_n);
            if (dout && !dout_prev) rise_t = cyc_n;
            if (!dout && dout_prev) hi_q.push_back(cyc_n - rise_t);
            dout_prev = dout;
            if (start && !busy && !rst) start_t = cyc_n;
            if (pix_valid && pix_ready) begin
                if (xfers == 0) first_xfer_t = cyc_n;
                xfers++;
            end
            if (frame_done) begin
                done_n++;
                done_t = cyc_n;
                busy_at_done = busy;
            end
            if (busy_prev && !busy) busy_falls++;
            busy_prev = busy;
        end
    end

    initial begin
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        forever begin
            @(negedge clk);
            fire = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            if (fire && pq.size() > 0) void'(pq.pop_front());
            if (pq.size() > 0 && cyc_n >= gate) begin
                pix_valid = 1'b1;
                pix_data  = pq[0];
            end else begin
                pix_valid = 1'b0;
                pix_data  = 8'h00;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_mon();
        strobe_q.delete();
        hi_q.delete();
        xfers = 0; done_n = 0; busy_falls = 0;
        start_t = -1; first_xfer_t = -1;
    endtask

    task automatic wait_strobes(input int n, input string tag);
        int k = 0;
        while (strobe_q.size() < n && k < 20000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (strobe_q.size() < n) check_eq({tag, " strobe timeout"}, strobe_q.size(), n);
    endtask

    task automatic wait_xfers(input int n, input string tag);
        int k = 0;
        while (xfers < n && k < 20000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (xfers < n) check_eq({tag, " xfer timeout"}, xfers, n);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_n < 1 && k < 20000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_n < 1) check_eq({tag, " done timeout"}, done_n, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    // Compares captured high phases and bit spacing against three pixel words.
    task automatic check_frame(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                               input logic [7:0] p2, input int skip_gap);
        logic [7:0] px [3];
        int bad;
        int exp;
        px[0] = p0; px[1] = p1; px[2] = p2;
        check_eq({tag, " strobes"}, strobe_q.size(), 24);
        check_eq({tag, " highs"}, hi_q.size(), 24);
        bad = 0;
        for (int i = 0; i < 24 && i < hi_q.size(); i++) begin
            exp = px[i / 8][7 - (i % 8)] ? 41 : 20;
            if (hi_q[i] != exp) bad++;
        end
        check_eq({tag, " high lengths"}, bad, 0);
        bad = 0;
        for (int i = 1; i < strobe_q.size(); i++) begin
            if (i != skip_gap && strobe_q[i] - strobe_q[i-1] != 63) bad++;
        end
        check_eq({tag, " bit periods"}, bad, 0);
    endtask

    initial begin
        int a5_hi [8];
        int s;
        a5_hi = '{41, 20, 41, 20, 20, 41, 20, 41};
        rst = 1'b1;
        start = 1'b0;
        clear_mon();
        idle_cycles(3);
        check_eq("rst dout", int'(dout), 0);
        check_eq("rst busy", int'(busy), 0);
        check_eq("rst pix_ready", int'(pix_ready), 0);
        check_eq("rst bit_strobe", int'(bit_strobe), 0);
        check_eq("rst frame_done", int'(frame_done), 0);
`ifdef LED_DRV_UNDERRUN_EN
        check_eq("rst underrun_err", int'(underrun_err), 0);
`endif
        tick();
        rst = 1'b0;
        idle_cycles(2);

        // Frame A: first pixel valid before start
        clear_mon();
        @(posedge clk); #2;
        pq.push_back(8'hA5); pq.push_back(8'hFF); pq.push_back(8'h00);
        idle_cycles(3);
        pulse_start();
        wait_done("A");
        idle_cycles(20);
        for (int i = 0; i < 8; i++) begin
            if (i < hi_q.size()) check_eq($sformatf("A a5 bit%0d high", i), hi_q[i], a5_hi[i]);
        end
        check_frame("A", 8'hA5, 8'hFF, 8'h00, -1);
        if (strobe_q.size() == 24) check_eq("A latch length", done_t - strobe_q[23], 63 + 3600);
        check_eq("A frame_done pulses", done_n, 1);
        check_eq("A busy at done", int'(busy_at_done), 0);
        check_eq("A busy after", int'(busy), 0);
        check_eq("A transfers", xfers, 3);

        // Frame B: start and pix_valid together; starts during SEND and LATCH ignored
        clear_mon();
        @(posedge clk); #2;
        gate = cyc_n + 1;
        pq.push_back(8'hFF); pq.push_back(8'h00); pq.push_back(8'h81);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_xfers(3, "B");
        idle_cycles(2);
        check_eq("B ready after last accept", int'(pix_ready), 0);
        check_eq("B first accept cycle", first_xfer_t, start_t + 1);
        if (strobe_q.size() > 0) check_eq("B first strobe cycle", strobe_q[0], start_t + 2);
        wait_strobes(6, "B");
        pulse_start();
        wait_strobes(24, "B");
        idle_cycles(63 + 100);
        pulse_start();
        wait_done("B");
        idle_cycles(20);
        check_frame("B", 8'hFF, 8'h00, 8'h81, -1);
        check_eq("B frame_done pulses", done_n, 1);
        check_eq("B busy falls", busy_falls, 1);
        check_eq("B busy after ignored start", int'(busy), 0);
        check_eq("B transfers", xfers, 3);

        // Frame C: second pixel withheld past the end of the first
        clear_mon();
        gate = 0;
        @(posedge clk); #2;
        pq.push_back(8'h0F);
        idle_cycles(3);
        pulse_start();
        wait_xfers(1, "C");
        gate = 32'h7fff_ffff;
        pq.push_back(8'hC3); pq.push_back(8'h55);
        wait_strobes(8, "C");
        if (strobe_q.size() >= 8) gate = strobe_q[7] + 263;
        wait_done("C");
        idle_cycles(5);
`ifdef LED_DRV_UNDERRUN_EN
        check_frame("C", 8'h0F, 8'h00, 8'hC3, -1);
        check_eq("C underrun_err set", int'(underrun_err), 1);
`else
        check_frame("C", 8'h0F, 8'hC3, 8'h55, 8);
        if (strobe_q.size() >= 9) check_eq("C stall gap", strobe_q[8] - strobe_q[7], 264);
`endif
        check_eq("C frame_done pulses", done_n, 1);
        pq.delete();
        gate = 0;
        idle_cycles(3);

        // Frame D: reset at cycle 10 of bit 3
        clear_mon();
        @(posedge clk); #2;
        pq.push_back(8'h3C); pq.push_back(8'h5A); pq.push_back(8'hC3);
        idle_cycles(3);
        pulse_start();
`ifdef LED_DRV_UNDERRUN_EN
        idle_cycles(1);
        check_eq("D underrun_err cleared by start", int'(underrun_err), 0);
`endif
        wait_strobes(4, "D");
        s = (strobe_q.size() >= 4) ? strobe_q[3] : cyc_n;
        while (cyc_n < s + 10) tick();
        rst = 1'b1;
        pq.delete();
        idle_cycles(1);
        check_eq("D rst dout", int'(dout), 0);
        check_eq("D rst busy", int'(busy), 0);
        check_eq("D rst pix_ready", int'(pix_ready), 0);
        tick();
        rst = 1'b0;
        idle_cycles(1);
        check_eq("D after rst busy", int'(busy), 0);
        check_eq("D after rst dout", int'(dout), 0);

        // Frame E: full frame after the aborted one
        clear_mon();
        @(posedge clk); #2;
        pq.push_back(8'hA5); pq.push_back(8'hFF); pq.push_back(8'h00);
        idle_cycles(3);
        pulse_start();
        wait_done("E");
        idle_cycles(5);
        check_frame("E", 8'hA5, 8'hFF, 8'h00, -1);
        check_eq("E transfers", xfers, 3);
        check_eq("E frame_done pulses", done_n, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
